// File: rtl/time_keeper.sv
// time_keeper: synchronises the slow divided clock, turns its rising edges
// into single-cycle ticks, prescales them to seconds and keeps a 24-hour
// BCD time of day with a validated load port.
module time_keeper #(
   parameter int TICKS_PER_SECOND = 1,
   parameter int SYNC_STAGES      = 2
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       tick_clk_in,
   input  logic       run,
   input  logic       load_en,
   input  logic [7:0] load_hh,
   input  logic [7:0] load_mm,
   input  logic [7:0] load_ss,
   output logic [7:0] hours,
   output logic [7:0] minutes,
   output logic [7:0] seconds,
   output logic       sec_pulse,
   output logic       min_pulse,
   output logic       day_pulse,
   output logic       load_err
);

   localparam int PW = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
   localparam logic [PW-1:0] PS_MAX = PW'(TICKS_PER_SECOND - 1);

   // The settle counter keeps the edge detector blind until the reset-cleared
   // synchroniser has flushed and the history flop holds a real sample, so a
   // tick_clk_in that is already high when reset drops is not seen as an edge.
   localparam int SW = $clog2(SYNC_STAGES + 2);
   localparam logic [SW-1:0] SETTLE_MAX = SW'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic [SW-1:0]          settle_q;
   logic                   sync_out;
   logic                   tick;

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    hours_q, hours_d;
   logic [7:0]    minutes_q, minutes_d;
   logic [7:0]    seconds_q, seconds_d;
   logic          sec_pulse_q, sec_pulse_d;
   logic          min_pulse_q, min_pulse_d;
   logic          day_pulse_q, day_pulse_d;
   logic          load_err_q, load_err_d;

   logic          load_valid;
   logic          sec_wrap, min_wrap, hr_wrap;
   logic [7:0]    sec_inc, min_inc, hr_inc;

   // Increment a two-digit BCD value; callers handle the modulo wrap.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) begin
         bcd_inc = {v[7:4] + 4'd1, 4'd0};
      end else begin
         bcd_inc = {v[7:4], v[3:0] + 4'd1};
      end
   endfunction

   // A field is loadable when both digits are decimal and it is within range.
   function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] maxv);
      bcd_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= maxv);
   endfunction

   // Synchroniser chain, history flop and post-reset settle counter.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         sync_q   <= '0;
         hist_q   <= 1'b0;
         settle_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], tick_clk_in};
         hist_q <= sync_q[SYNC_STAGES-1];
         if (settle_q != SETTLE_MAX) begin
            settle_q <= settle_q + SW'(1);
         end
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign tick     = (settle_q == SETTLE_MAX) && sync_out && !hist_q;

   assign load_valid = bcd_ok(load_hh, 8'h23) && bcd_ok(load_mm, 8'h59) &&
                       bcd_ok(load_ss, 8'h59);

   assign sec_wrap = (seconds_q == 8'h59);
   assign min_wrap = (minutes_q == 8'h59);
   assign hr_wrap  = (hours_q   == 8'h23);
   assign sec_inc  = bcd_inc(seconds_q);
   assign min_inc  = bcd_inc(minutes_q);
   assign hr_inc   = bcd_inc(hours_q);

   // Next-state selection: a valid load beats a second advance; a rejected
   // load only raises load_err and lets counting carry on.
   always_comb begin
      presc_d     = presc_q;
      hours_d     = hours_q;
      minutes_d   = minutes_q;
      seconds_d   = seconds_q;
      sec_pulse_d = 1'b0;
      min_pulse_d = 1'b0;
      day_pulse_d = 1'b0;
      load_err_d  = load_en && !load_valid;

      if (load_en && load_valid) begin
         hours_d   = load_hh;
         minutes_d = load_mm;
         seconds_d = load_ss;
         presc_d   = '0;
      end else if (tick && run) begin
         if (presc_q == PS_MAX) begin
            presc_d     = '0;
            sec_pulse_d = 1'b1;
            seconds_d   = sec_wrap ? 8'h00 : sec_inc;
            if (sec_wrap) begin
               min_pulse_d = 1'b1;
               minutes_d   = min_wrap ? 8'h00 : min_inc;
               if (min_wrap) begin
                  hours_d     = hr_wrap ? 8'h00 : hr_inc;
                  day_pulse_d = hr_wrap;
               end
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   // Time, prescaler and pulse registers.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         presc_q     <= '0;
         hours_q     <= 8'h00;
         minutes_q   <= 8'h00;
         seconds_q   <= 8'h00;
         sec_pulse_q <= 1'b0;
         min_pulse_q <= 1'b0;
         day_pulse_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         hours_q     <= hours_d;
         minutes_q   <= minutes_d;
         seconds_q   <= seconds_d;
         sec_pulse_q <= sec_pulse_d;
         min_pulse_q <= min_pulse_d;
         day_pulse_q <= day_pulse_d;
         load_err_q  <= load_err_d;
      end
   end

   assign hours     = hours_q;
   assign minutes   = minutes_q;
   assign seconds   = seconds_q;
   assign sec_pulse = sec_pulse_q;
   assign min_pulse = min_pulse_q;
   assign day_pulse = day_pulse_q;
   assign load_err  = load_err_q;

endmodule

// File: tb/tb_time_keeper.sv
// Testbench for time_keeper: two instances (1 and 4 ticks per second) share
// one stimulus stream; expected pulse events go into per-instance queues and
// monitors pop and compare whenever an instance raises any pulse.
module tb_time_keeper;

   typedef struct packed {
      logic [7:0] hh;
      logic [7:0] mm;
      logic [7:0] ss;
      logic       sp;
      logic       mp;
      logic       dp;
      logic       er;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick_clk_in;
   logic       run;
   logic       load_en;
   logic [7:0] load_hh, load_mm, load_ss;

   logic [7:0] h1, m1, s1, h4, m4, s4;
   logic       sp1, mp1, dp1, er1, sp4, mp4, dp4, er4;

   int checks = 0;
   int errors = 0;
   exp_t q1[$];
   exp_t q4[$];

   always #5 clk = ~clk;

   time_keeper #(.TICKS_PER_SECOND(1), .SYNC_STAGES(2)) dut1 (
      .clk_in(clk), .reset(reset), .tick_clk_in(tick_clk_in), .run(run),
      .load_en(load_en), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
      .hours(h1), .minutes(m1), .seconds(s1),
      .sec_pulse(sp1), .min_pulse(mp1), .day_pulse(dp1), .load_err(er1)
   );

   time_keeper #(.TICKS_PER_SECOND(4), .SYNC_STAGES(2)) dut4 (
      .clk_in(clk), .reset(reset), .tick_clk_in(tick_clk_in), .run(run),
      .load_en(load_en), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
      .hours(h4), .minutes(m4), .seconds(s4),
      .sec_pulse(sp4), .min_pulse(mp4), .day_pulse(dp4), .load_err(er4)
   );

   function automatic exp_t mk(input logic [7:0] hh, input logic [7:0] mm,
                               input logic [7:0] ss, input logic sp,
                               input logic mp, input logic dp, input logic er);
      exp_t e;
      e.hh = hh; e.mm = mm; e.ss = ss;
      e.sp = sp; e.mp = mp; e.dp = dp; e.er = er;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   // Advance n clocks and park 1 time unit after the last rising edge.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rise();
      tick_clk_in = 1'b1;
      cyc(6);
      tick_clk_in = 1'b0;
      cyc(6);
   endtask

   task automatic do_load(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
      load_hh = hh; load_mm = mm; load_ss = ss;
      load_en = 1'b1;
      cyc(1);
      load_en = 1'b0;
   endtask

   // Monitor for the 1-tick-per-second instance.
   always @(negedge clk) begin
      exp_t a, e;
      if (sp1 | mp1 | dp1 | er1) begin
         a = mk(h1, m1, s1, sp1, mp1, dp1, er1);
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL sb1 unexpected event got %h", a);
         end else begin
            e = q1.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL sb1 event got %h expected %h", a, e);
            end else begin
               $display("ok   sb1 %h:%h:%h s%0b m%0b d%0b e%0b", a.hh, a.mm, a.ss, a.sp, a.mp, a.dp, a.er);
            end
         end
      end
   end

   // Monitor for the 4-ticks-per-second instance.
   always @(negedge clk) begin
      exp_t a, e;
      if (sp4 | mp4 | dp4 | er4) begin
         a = mk(h4, m4, s4, sp4, mp4, dp4, er4);
         checks++;
         if (q4.size() == 0) begin
            errors++;
            $display("FAIL sb4 unexpected event got %h", a);
         end else begin
            e = q4.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL sb4 event got %h expected %h", a, e);
            end else begin
               $display("ok   sb4 %h:%h:%h s%0b m%0b d%0b e%0b", a.hh, a.mm, a.ss, a.sp, a.mp, a.dp, a.er);
            end
         end
      end
   end

   logic [7:0] bad_hh[3] = '{8'h24, 8'h12, 8'h12};
   logic [7:0] bad_mm[3] = '{8'h00, 8'h60, 8'h0A};
   logic [7:0] t5_ss[4]  = '{8'h08, 8'h09, 8'h10, 8'h11};

   initial begin
      reset = 1'b1; tick_clk_in = 1'b1; run = 1'b1; load_en = 1'b0;
      load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
      cyc(4);
      chk("reset_state1", {4'h0, h1, m1, s1, sp1, mp1, dp1, er1}, 32'h0);
      chk("reset_state4", {4'h0, h4, m4, s4, sp4, mp4, dp4, er4}, 32'h0);
      reset = 1'b0;
      // tick_clk_in still high across reset release: no tick allowed
      cyc(10);
      chk("post_release1", {8'h0, h1, m1, s1}, 32'h0);
      chk("post_release4", {8'h0, h4, m4, s4}, 32'h0);

      // first genuine rise: pulse 3 edges after it is first sampled
      tick_clk_in = 1'b0;
      cyc(6);
      q1.push_back(mk(8'h00, 8'h00, 8'h01, 1, 0, 0, 0));
      tick_clk_in = 1'b1;
      cyc(2);
      chk("latency_early", {31'h0, sp1}, 32'h0);
      cyc(1);
      chk("latency_hit", {31'h0, sp1}, 32'h1);
      chk("first_second", {24'h0, s1}, 32'h01);
      cyc(3);
      tick_clk_in = 1'b0;
      cyc(6);

      // day wrap on the 1-tick instance
      do_load(8'h23, 8'h59, 8'h58);
      chk("load_235958_1", {8'h0, h1, m1, s1}, 32'h235958);
      chk("load_235958_4", {8'h0, h4, m4, s4}, 32'h235958);
      q1.push_back(mk(8'h23, 8'h59, 8'h59, 1, 0, 0, 0));
      rise();
      q1.push_back(mk(8'h00, 8'h00, 8'h00, 1, 1, 1, 0));
      rise();
      chk("prescaled_hold4", {8'h0, h4, m4, s4}, 32'h235958);

      // prescaling by 4
      do_load(8'h00, 8'h00, 8'h00);
      for (int r = 0; r < 8; r++) begin
         q1.push_back(mk(8'h00, 8'h00, 8'(r + 1), 1, 0, 0, 0));
         if (r == 3) q4.push_back(mk(8'h00, 8'h00, 8'h01, 1, 0, 0, 0));
         if (r == 7) q4.push_back(mk(8'h00, 8'h00, 8'h02, 1, 0, 0, 0));
         rise();
      end
      chk("presc_secs4", {24'h0, s4}, 32'h02);
      chk("presc_secs1", {24'h0, s1}, 32'h08);

      // rejected loads
      do_load(8'h10, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) begin
         q1.push_back(mk(8'h10, 8'h00, 8'h00, 0, 0, 0, 1));
         q4.push_back(mk(8'h10, 8'h00, 8'h00, 0, 0, 0, 1));
         do_load(bad_hh[i], bad_mm[i], 8'h00);
         cyc(2);
         chk("bad_load_hold1", {8'h0, h1, m1, s1}, 32'h100000);
         chk("bad_load_hold4", {8'h0, h4, m4, s4}, 32'h100000);
      end

      // valid load coincident with an advancing tick
      do_load(8'h01, 8'h02, 8'h03);
      tick_clk_in = 1'b1;
      cyc(2);
      load_hh = 8'h05; load_mm = 8'h06; load_ss = 8'h07; load_en = 1'b1;
      cyc(1);
      load_en = 1'b0;
      chk("load_wins1", {8'h0, h1, m1, s1}, 32'h050607);
      chk("load_wins4", {8'h0, h4, m4, s4}, 32'h050607);
      chk("load_wins_nopulse", {28'h0, sp1, mp1, dp1, er1}, 32'h0);
      cyc(3);
      tick_clk_in = 1'b0;
      cyc(6);
      for (int r = 0; r < 4; r++) begin
         q1.push_back(mk(8'h05, 8'h06, t5_ss[r], 1, 0, 0, 0));
         if (r == 3) q4.push_back(mk(8'h05, 8'h06, 8'h08, 1, 0, 0, 0));
         rise();
      end

      // run=0 discards ticks
      do_load(8'h12, 8'h34, 8'h56);
      run = 1'b0;
      repeat (5) rise();
      chk("frozen1", {8'h0, h1, m1, s1}, 32'h123456);
      chk("frozen4", {8'h0, h4, m4, s4}, 32'h123456);
      run = 1'b1;
      q1.push_back(mk(8'h12, 8'h34, 8'h57, 1, 0, 0, 0));
      rise();
      q1.push_back(mk(8'h12, 8'h34, 8'h58, 1, 0, 0, 0));
      rise();
      q1.push_back(mk(8'h12, 8'h34, 8'h59, 1, 0, 0, 0));
      rise();
      q1.push_back(mk(8'h12, 8'h35, 8'h00, 1, 1, 0, 0));
      q4.push_back(mk(8'h12, 8'h34, 8'h57, 1, 0, 0, 0));
      rise();

      // reset beats a simultaneous valid load
      load_hh = 8'h11; load_mm = 8'h11; load_ss = 8'h11;
      load_en = 1'b1; reset = 1'b1;
      cyc(1);
      load_en = 1'b0; reset = 1'b0;
      chk("reset_over_load1", {8'h0, h1, m1, s1}, 32'h0);
      chk("reset_over_load4", {8'h0, h4, m4, s4}, 32'h0);

      cyc(5);
      chk("sb1_drained", q1.size(), 32'h0);
      chk("sb4_drained", q4.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
